fkey_dec: RTL
=============

# fkey_dec

Streaming decoder turning 32-bit order-preserving sort keys back into IEEE-754 single-precision values. The keys are the unsigned-comparable encoding our FPU comparators build internally: sign flipped for positives, all bits inverted for negatives, zero/subnormal flushed to +0. The block sits at the output of the hardware sorter and restores floats for the writeback path. It uses a 2-stage valid/ready pipeline with a beat counter and an optional in-packet ordering check.

## Interface
- COUNT_W, 16, width of output beat counter
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- k_valid  in  1  input key valid
- k_ready  out  1  block can accept key
- k  in  32  sort key
- k_last  in  1  last key of packet
- y_valid  out  1  output float valid
- y_ready  in  1  downstream accepts
- y  out  32  decoded IEEE-754 single
- y_last  out  1  k_last carried through
- y_nc  out  1  this beat came from a non-canonical key
- cnt  out  COUNT_W  number of y beats accepted since reset
- ord_err  out  1  sticky ordering error (only with FKEY_DEC_ORDER_CHECK_EN)

## Operation
- Decode, when k[31]=1: s=0, e=k[30:23], m=k[22:0].
- Decode, when k[31]=0: s=1, e=~k[30:23], m=~k[22:0].
- Non-canonical keys decode to y=32'h0000_0000 with y_nc=1:
  - k[31]=1, k[30:23]=0, k[22:0]!=0 (subnormal payload);
  - k[31]=0, k[30:23]=8'hFF (negative zero/subnormal).
- Key 32'h8000_0000 decodes to +0 with y_nc=0.
- Inf and NaN keys decode bit-exactly. There is no NaN canonicalisation.
- Stage 1 registers the decoded value, nc and last. Stage 2 is the output register.
- A stage loads when it is empty or its contents leave in the same cycle.
- k_ready = ~s1_valid | s1_advance. This is a combinational path from y_ready; no skid buffer.
- cnt increments on each y_valid & y_ready. It wraps modulo 2^COUNT_W.

## Timing
- Reset: k_ready=1 in the first cycle after reset. All of the following are 0: y_valid, y, y_last, y_nc, cnt, ord_err, both stage valids, prev-key register.
- Latency: a key accepted in cycle N appears on y with y_valid=1 in cycle N+2, provided y_ready has been high.
- Throughput: 1 beat/cycle with y_ready held high.
- Stall: y_valid, y, y_last and y_nc hold stable while y_valid & ~y_ready. Pipeline holds 2 beats, then k_ready=0.
- Simultaneous accept at input and output: both occur in the same cycle, with no bubble.
- Reset mid-packet: in-flight beats are discarded, and the ordering context restarts.

## Configuration
- FKEY_DEC_ORDER_CHECK_EN defined:
  - Each accepted key is compared unsigned with the previous accepted key of the same packet.
  - k < prev sets ord_err, which stays high until rst.
  - The first key after reset or after a k_last beat is never flagged.
  - The check is performed at input accept. ord_err rises the cycle after the offending accept.
- Not defined: ord_err is tied to 0, and no prev-key register is built.

## Structure
- fpu_pkg holds:
  - typedef fp32_t as a packed struct {s, e[7:0], m[22:0]};
  - constants KEY_POS_ZERO=32'h8000_0000 and EXP_MAX=8'hFF.
- Sub-module fkey_unmap is purely combinational: k in, y and nc out.
- fkey_dec instantiates fkey_unmap once, ahead of stage 1. It also contains the pipeline, counter and order check.

## Test plan
- k=32'hBF80_0000 then k=32'h407F_FFFF, y_ready=1 -> y=32'h3F80_0000 at N+2, y=32'hBF80_0000 at N+3, y_nc=0, cnt=2.
- k=32'h8000_0000 -> y=0, y_nc=0. k=32'h8000_0001 -> y=0, y_nc=1. k=32'h7F80_0000 -> y=0, y_nc=1.
- k=32'hFF80_0000 -> y=32'h7F80_0000 (+Inf). k=32'hFFC0_0000 -> y=32'h7FC0_0000.
- Stream 5 keys with y_ready low for cycles 3-6 -> k_ready=0 after 2 accepts, y held stable, all 5 emitted in order with no loss or duplication.
- With FKEY_DEC_ORDER_CHECK_EN, packet 32'h407F_FFFF, 32'hBF80_0000, 32'h8000_0000 (last) -> ord_err=1 one cycle after third accept. A new packet starting with 32'h0000_0000 does not flag.
- COUNT_W=4, 17 beats -> cnt=1. Assert rst mid-stream -> all outputs 0 the next cycle and k_ready=1.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the sort-key decode path.
package fpu_pkg;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } fp32_t;

  localparam logic [31:0] KEY_POS_ZERO = 32'h8000_0000;
  localparam logic [7:0]  EXP_MAX      = 8'hFF;

endpackage

// File: rtl/fkey_dec_if.sv
// Key-in / float-out valid/ready bundle for fkey_dec.
interface fkey_dec_if;
  logic        k_valid;
  logic        k_ready;
  logic [31:0] k;
  logic        k_last;
  logic        y_valid;
  logic        y_ready;
  logic [31:0] y;
  logic        y_last;
  logic        y_nc;

  modport master (
    output k_valid, k, k_last, y_ready,
    input  k_ready, y_valid, y, y_last, y_nc
  );

  modport slave (
    input  k_valid, k, k_last, y_ready,
    output k_ready, y_valid, y, y_last, y_nc
  );
endinterface

// File: rtl/fkey_unmap.sv
// Combinational inverse of the order-preserving float sort-key mapping.
module fkey_unmap
  import fpu_pkg::*;
(
  input  logic [31:0] i_k,
  output fp32_t       o_y,
  output logic        o_nc
);

  always_comb begin
    o_y  = '0;
    o_nc = 1'b0;
    if (i_k[31]) begin
      // Positive: only the +0 key may carry a zero exponent.
      if (i_k[30:23] == 8'h00 && i_k != KEY_POS_ZERO) begin
        o_nc = 1'b1;
      end else begin
        o_y = {1'b0, i_k[30:0]};
      end
    end else begin
      if (i_k[30:23] == EXP_MAX) begin
        o_nc = 1'b1;
      end else begin
        o_y = ~i_k;
      end
    end
  end

endmodule

// File: rtl/fkey_dec.sv
// Two-stage valid/ready sort-key to IEEE-754 decoder with beat counter.
// Optional in-packet ordering check: define FKEY_DEC_ORDER_CHECK_EN.
module fkey_dec
  import fpu_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  fkey_dec_if.slave          bus,
  output logic [COUNT_W-1:0] cnt,
  output logic               ord_err
);

  fp32_t w_y;
  logic  w_nc;

  fkey_unmap u_unmap (
    .i_k  (bus.k),
    .o_y  (w_y),
    .o_nc (w_nc)
  );

  logic               r_s1_valid, r_s1_nc, r_s1_last;
  fp32_t              r_s1_y;
  logic               r_s2_valid, r_s2_nc, r_s2_last;
  fp32_t              r_s2_y;
  logic [COUNT_W-1:0] r_cnt;
  logic               w_s2_load, w_s1_adv, w_k_acc, w_y_acc;

  assign w_s2_load   = ~r_s2_valid | bus.y_ready;
  assign w_s1_adv    = r_s1_valid & w_s2_load;
  assign bus.k_ready = ~r_s1_valid | w_s1_adv;
  assign w_k_acc     = bus.k_valid & bus.k_ready;
  assign w_y_acc     = r_s2_valid & bus.y_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_nc    <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_y     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_nc    <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_y     <= '0;
      r_cnt      <= '0;
    end else begin
      if (bus.k_ready) begin
        r_s1_valid <= bus.k_valid;
        if (bus.k_valid) begin
          r_s1_y    <= w_y;
          r_s1_nc   <= w_nc;
          r_s1_last <= bus.k_last;
        end
      end
      // Output data only changes on a real load so it stays put while stalled.
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_y    <= r_s1_y;
          r_s2_nc   <= r_s1_nc;
          r_s2_last <= r_s1_last;
        end
      end
      if (w_y_acc) begin
        r_cnt <= r_cnt + COUNT_W'(1);
      end
    end
  end

  assign bus.y_valid = r_s2_valid;
  assign bus.y       = r_s2_y;
  assign bus.y_last  = r_s2_last;
  assign bus.y_nc    = r_s2_nc;
  assign cnt         = r_cnt;

`ifdef FKEY_DEC_ORDER_CHECK_EN
  logic [31:0] r_prev;
  logic        r_first;
  logic        r_ord_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= '0;
      r_first   <= 1'b1;
      r_ord_err <= 1'b0;
    end else if (w_k_acc) begin
      if (!r_first && bus.k < r_prev) begin
        r_ord_err <= 1'b1;
      end
      r_prev  <= bus.k;
      r_first <= bus.k_last;
    end
  end

  assign ord_err = r_ord_err;
`else
  assign ord_err = 1'b0;
`endif

endmodule
